// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package ifetch_queue_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = 32'hC400_0000;
    localparam word_t PC_STEP   = 32'd4;

    function automatic word_t pc_inc(input word_t pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular instruction buffer: DEPTH x 32 entries, in-order, combinational head read.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [31:0]                  i_wdata,
    input  logic                         i_pop,
    output logic [31:0]                  o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    word_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == DEPTH_C);
    assign w_do_push = i_push && !i_flush;
    assign w_do_pop  = i_pop && !i_flush && !o_empty;

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front-end: issues sequential imem requests, queues returned words in order,
// and flushes (dropping in-flight returns) on redirect.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall_d,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_instr_valid,
    output logic [31:0] o_instr_f,
    output logic [31:0] o_pc_f,
    output logic [31:0] o_pcplus4_f
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0] MAX_OUTST_C = OW'(MAX_OUTST);
    localparam logic [31:0]   DEPTH_W     = 32'(DEPTH);

    word_t          r_fetch_pc;
    word_t          r_head_pc;
    logic [OW-1:0]  r_outst;
    logic [OW-1:0]  r_drop;

    logic [OW-1:0]  w_outst_next;
    logic [CW-1:0]  w_count;
    logic [31:0]    w_occupancy;
    logic           w_empty;
    logic           w_full;
    logic           w_grant;
    logic           w_push;
    logic           w_pop;
    word_t          w_head;

    // Every outstanding request owns a queue slot, so a return always fits.
    assign w_occupancy  = 32'(w_count) + 32'(r_outst);
    assign o_imem_req   = rst_n && !i_redirect && (r_outst < MAX_OUTST_C)
                          && (w_occupancy < DEPTH_W);
    assign o_imem_addr  = r_fetch_pc;
    assign w_grant      = o_imem_req && i_imem_gnt;
    assign w_outst_next = r_outst + OW'(w_grant) - OW'(i_imem_rvalid);

    assign w_push = i_imem_rvalid && !i_redirect && (r_drop == '0);
    assign w_pop  = !w_empty && !i_stall_d && !i_redirect;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_redirect),
        .i_push  (w_push),
        .i_wdata (i_imem_rdata),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= w_outst_next;
            if (i_redirect) begin
                r_fetch_pc <= i_redirect_pc;
                r_head_pc  <= i_redirect_pc;
                // Everything still in flight after this cycle belongs to the old stream.
                r_drop     <= w_outst_next;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= pc_inc(r_fetch_pc);
                end
                if (w_pop) begin
                    r_head_pc <= pc_inc(r_head_pc);
                end
                if (i_imem_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - OW'(1);
                end
            end
        end
    end

    assign o_instr_valid = !w_empty;
    assign o_instr_f     = w_empty ? NOP_INSTR : w_head;
    assign o_pc_f        = r_head_pc;
    assign o_pcplus4_f   = pc_inc(r_head_pc);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && w_full));
    a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_imem_rvalid && (r_outst == '0)));
    a_redirect_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_redirect && (i_redirect_pc[1:0] != 2'b00)));

endmodule
